// File: rtl/ex_mdu.sv
// ex_mdu: multi-cycle multiply/divide unit in the EX stage.
// Owns the HI/LO registers; results land after a fixed busy window.
module ex_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        read_sel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] result
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [0:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [31:0]      pend_hi, pend_hi_nx;
    logic [31:0]      pend_lo, pend_lo_nx;
    logic [31:0]      hi_nx, lo_nx;

    logic [63:0] prod_s, prod_u;
    logic        is_sdiv, a_neg, b_neg;
    logic [31:0] dvd, dvs, q_raw, r_raw, q_fix, r_fix;

    // Arithmetic datapath: products and a sign-magnitude divider on the live operands
    always_comb begin
        prod_s  = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
        prod_u  = {32'd0, srcA} * {32'd0, srcB};
        is_sdiv = (md_op == OP_DIV);
        a_neg   = is_sdiv & srcA[31];
        b_neg   = is_sdiv & srcB[31];
        dvd     = a_neg ? (~srcA + 32'd1) : srcA;
        dvs     = b_neg ? (~srcB + 32'd1) : srcB;
        // Zero divisor is replaced so the divider never sees it; the result is discarded anyway
        if (dvs == 32'd0) begin
            dvs = 32'd1;
        end
        q_raw = dvd / dvs;
        r_raw = dvd % dvs;
        q_fix = (a_neg ^ b_neg) ? (~q_raw + 32'd1) : q_raw;
        r_fix = a_neg ? (~r_raw + 32'd1) : r_raw;
    end

    // Next-state logic: start, countdown, commit and move-to writes
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        pend_hi_nx = pend_hi;
        pend_lo_nx = pend_lo;
        hi_nx      = hi;
        lo_nx      = lo;
        case (state)
            IDLE: begin
                case (md_op)
                    OP_MULT: begin
                        pend_hi_nx = prod_s[63:32];
                        pend_lo_nx = prod_s[31:0];
                        cnt_nx     = CNT_W'(MULT_CYCLES);
                        state_nx   = RUN;
                    end
                    OP_MULTU: begin
                        pend_hi_nx = prod_u[63:32];
                        pend_lo_nx = prod_u[31:0];
                        cnt_nx     = CNT_W'(MULT_CYCLES);
                        state_nx   = RUN;
                    end
                    OP_DIV, OP_DIVU: begin
                        // Divide by zero commits the current HI/LO, leaving them unchanged
                        if (srcB == 32'd0) begin
                            pend_hi_nx = hi;
                            pend_lo_nx = lo;
                        end else begin
                            pend_hi_nx = r_fix;
                            pend_lo_nx = q_fix;
                        end
                        cnt_nx   = CNT_W'(DIV_CYCLES);
                        state_nx = RUN;
                    end
                    OP_MTHI: hi_nx = srcA;
                    OP_MTLO: lo_nx = srcA;
                    default: ;
                endcase
            end
            RUN: begin
                // Any md_op arriving here is ignored
                if (cnt == CNT_W'(1)) begin
                    hi_nx    = pend_hi;
                    lo_nx    = pend_lo;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    // State and architectural registers; reset discards any in-flight result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            pend_hi <= pend_hi_nx;
            pend_lo <= pend_lo_nx;
            hi      <= hi_nx;
            lo      <= lo_nx;
        end
    end

    assign busy   = (state == RUN);
    assign result = read_sel ? hi : lo;

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed vectors for ex_mdu with hand-computed HI/LO results.
module tb_ex_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  md_op;
    logic [31:0] srcA, srcB;
    logic        read_sel;
    logic        busy;
    logic [31:0] hi, lo, result;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] cur_hi = 32'd0;
    logic [31:0] cur_lo = 32'd0;

    ex_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_op    (md_op),
        .srcA     (srcA),
        .srcB     (srcB),
        .read_sel (read_sel),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .result   (result)
    );

    always #5 clk = ~clk;

    // Single comparison point for every check
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // mthi/mtlo from IDLE; called at a negedge, returns at a negedge
    task automatic do_mt(input logic [2:0] op, input logic [31:0] val, input string tag);
        md_op = op;
        srcA  = val;
        @(posedge clk);
        @(negedge clk);
        md_op = 3'd0;
        if (op == 3'd5) cur_hi = val;
        else            cur_lo = val;
        chk({tag, "/busy"}, 32'(busy), 32'd0);
        chk({tag, "/hi"}, hi, cur_hi);
        chk({tag, "/lo"}, lo, cur_lo);
    endtask

    // Start an operation, watch the busy window, then check the committed HI/LO and result mux
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_cycles, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit interfere, input string tag);
        int n;
        md_op = op;
        srcA  = a;
        srcB  = b;
        @(posedge clk);
        @(negedge clk);
        md_op = 3'd0;
        srcA  = ~a;
        srcB  = 32'h1;
        n     = 0;
        while (busy === 1'b1 && n < 60) begin
            n++;
            chk({tag, "/hold_hi"}, hi, cur_hi);
            chk({tag, "/hold_lo"}, lo, cur_lo);
            if (interfere) begin
                if (n == 1) begin
                    md_op = 3'd5;
                    srcA  = 32'h0000DEAD;
                end else if (n == 2) begin
                    md_op = 3'd3;
                    srcA  = 32'd100;
                    srcB  = 32'd7;
                end else begin
                    md_op = 3'd0;
                end
            end
            @(negedge clk);
        end
        md_op = 3'd0;
        chk({tag, "/busy_cycles"}, 32'(n), 32'(exp_cycles));
        cur_hi = exp_hi;
        cur_lo = exp_lo;
        chk({tag, "/hi"}, hi, cur_hi);
        chk({tag, "/lo"}, lo, cur_lo);
        read_sel = 1'b1;
        #1 chk({tag, "/result_hi"}, result, cur_hi);
        read_sel = 1'b0;
        #1 chk({tag, "/result_lo"}, result, cur_lo);
    endtask

    initial begin
        reset    = 1'b1;
        md_op    = 3'd0;
        srcA     = 32'd0;
        srcB     = 32'd0;
        read_sel = 1'b0;
        #2;
        chk("reset/busy", 32'(busy), 32'd0);
        chk("reset/hi", hi, 32'd0);
        chk("reset/lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Multiply
        do_mt(3'd5, 32'h11111111, "pre_hi");
        do_mt(3'd6, 32'h22222222, "pre_lo");
        run_op(3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, "mult");
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu");

        // Divide
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_neg");
        run_op(3'd3, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, 1'b0, "div_negdiv");
        run_op(3'd4, 32'd7, 32'd2, 10, 32'h00000001, 32'h00000003, 1'b0, "divu");
        run_op(3'd4, 32'hFFFFFFFF, 32'h10, 10, 32'h0000000F, 32'h0FFFFFFF, 1'b0, "divu_big");
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, 1'b0, "div_ovf");

        // Divide by zero leaves HI/LO untouched
        do_mt(3'd5, 32'h00001234, "mthi");
        do_mt(3'd6, 32'h00005678, "mtlo");
        run_op(3'd3, 32'd99, 32'd0, 10, 32'h00001234, 32'h00005678, 1'b0, "div0");
        run_op(3'd4, 32'd99, 32'd0, 10, 32'h00001234, 32'h00005678, 1'b0, "divu0");

        // No-op codes
        md_op = 3'd7;
        srcA  = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        md_op = 3'd0;
        chk("op7/busy", 32'(busy), 32'd0);
        chk("op7/hi", hi, cur_hi);
        chk("op7/lo", lo, cur_lo);

        // Ops issued while busy are ignored
        run_op(3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1, "busy_ign");

        // Reset in the middle of a divide
        do_mt(3'd5, 32'hAAAA0000, "rst_pre_hi");
        md_op = 3'd4;
        srcA  = 32'd100;
        srcB  = 32'd3;
        @(posedge clk);
        @(negedge clk);
        md_op = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_mid/busy_before", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid/busy", 32'(busy), 32'd0);
        chk("rst_mid/hi", hi, 32'd0);
        chk("rst_mid/lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("rst_after/busy", 32'(busy), 32'd0);
        chk("rst_after/hi", hi, 32'd0);
        chk("rst_after/lo", lo, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
